lane_color_mapper_fx: RTL and testbench

//  Parametrised, registered successor to the combinational lane colour mapper in the VGA path.

---
 rtl/lane_color_mapper_fx_if.sv | 28 ++
 rtl/lane_color_mapper_fx.sv | 113 +++++++++++
 tb/tb_lane_color_mapper_fx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lane_color_mapper_fx_if.sv
// Pixel-path bundle between the hit logic / pixel sources and the lane colour mapper.
interface lane_color_mapper_fx_if #(
  parameter int unsigned N_LANES = 8
);
  logic               frame_start;
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic               is_num;
  logic [N_LANES-1:0] is_sr;
  logic [N_LANES-1:0] keyTrack;
  logic [N_LANES-1:0] hit;
  logic [N_LANES-1:0] miss;
  logic [7:0]         VGA_R;
  logic [7:0]         VGA_G;
  logic [7:0]         VGA_B;

  // Upstream side: drives pixel flags and judgements, receives RGB.
  modport master (
    output frame_start, DrawX, DrawY, is_num, is_sr, keyTrack, hit, miss,
    input  VGA_R, VGA_G, VGA_B
  );

  // Mapper side.
  modport slave (
    input  frame_start, DrawX, DrawY, is_num, is_sr, keyTrack, hit, miss,
    output VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/lane_color_mapper_fx.sv
// Registered lane colour mapper: score digits, note lanes with per-lane hit/miss flash
// effects timed in frames, then background with optional DrawY gradient on green.
module lane_color_mapper_fx #(
  parameter int unsigned N_LANES      = 8,
  parameter int unsigned FLASH_FRAMES = 6,
  parameter bit          GRADIENT     = 1'b0,
  parameter logic [7:0]  BG_R         = 8'h00,
  parameter logic [7:0]  BG_G         = 8'h00,
  parameter logic [7:0]  BG_B         = 8'h00
) (
  input logic                    Clk,
  input logic                    Reset_n,
  lane_color_mapper_fx_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StHitFl, StMissFl} lane_st_e;

  localparam logic [5:0] FlashLoad = 6'(FLASH_FRAMES);

  lane_st_e   r_state_q [N_LANES];
  lane_st_e   w_state_d [N_LANES];
  logic [5:0] r_cnt_q   [N_LANES];
  logic [5:0] w_cnt_d   [N_LANES];
  logic [23:0] r_rgb_q;
  logic [23:0] w_rgb_d;
  logic [8:0]  w_g_sum;

  // DrawX is reserved for future modes; DrawY[2:0] is below gradient resolution.
  logic w_unused_ok;
  assign w_unused_ok = ^{bus.DrawX, bus.DrawY[2:0]};

  // Lane i uses palette entry i mod 4; bright when the lane key is held.
  function automatic logic [23:0] palette(input logic [1:0] sel, input logic bright);
    logic [23:0] c;
    c = 24'h000000;
    unique case (sel)
      2'd0: c = bright ? 24'h00FD00 : 24'h00D600;
      2'd1: c = bright ? 24'h0000FF : 24'h0000C9;
      2'd2: c = bright ? 24'hFFFF00 : 24'hF2F200;
      2'd3: c = bright ? 24'hFF0000 : 24'hAF0000;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Gradient sum kept 9 bits wide so the clamp sees the carry.
  assign w_g_sum = {1'b0, BG_G} + {2'b00, bus.DrawY[9:3]};

  // Per-lane flash FSM next state: pulses load (hit beats miss), frame_start counts down.
  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      w_state_d[i] = r_state_q[i];
      w_cnt_d[i]   = r_cnt_q[i];
      if (bus.hit[i]) begin
        w_state_d[i] = StHitFl;
        w_cnt_d[i]   = FlashLoad;
      end else if (bus.miss[i]) begin
        w_state_d[i] = StMissFl;
        w_cnt_d[i]   = FlashLoad;
      end else if (bus.frame_start && (r_state_q[i] != StIdle)) begin
        if (r_cnt_q[i] == 6'd1) begin
          w_state_d[i] = StIdle;
          w_cnt_d[i]   = 6'd0;
        end else begin
          w_cnt_d[i]   = r_cnt_q[i] - 6'd1;
        end
      end
    end
  end

  // Pixel colour selection from the lane state held before this edge.
  always_comb begin
    w_rgb_d = {BG_R, BG_G, BG_B};
    if (GRADIENT) begin
      w_rgb_d[15:8] = w_g_sum[8] ? 8'hFF : w_g_sum[7:0];
    end
    // Ascending scan so the highest-index active lane wins.
    for (int i = 0; i < N_LANES; i++) begin
      if (bus.is_sr[i]) begin
        unique case (r_state_q[i])
          StHitFl:  w_rgb_d = palette(2'(i), 1'b1) | 24'h808080;
          StMissFl: w_rgb_d = 24'h600000;
          default:  w_rgb_d = palette(2'(i), bus.keyTrack[i]);
        endcase
      end
    end
    if (bus.is_num) begin
      w_rgb_d = 24'hFFFFFF;
    end
  end

  // State, counters and RGB register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_LANES; i++) begin
        r_state_q[i] <= StIdle;
        r_cnt_q[i]   <= 6'd0;
      end
      r_rgb_q <= 24'h000000;
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        r_state_q[i] <= w_state_d[i];
        r_cnt_q[i]   <= w_cnt_d[i];
      end
      r_rgb_q <= w_rgb_d;
    end
  end

  assign bus.VGA_R = r_rgb_q[23:16];
  assign bus.VGA_G = r_rgb_q[15:8];
  assign bus.VGA_B = r_rgb_q[7:0];

endmodule

// File: tb/tb_lane_color_mapper_fx.sv
// Directed bench for lane_color_mapper_fx: default instance plus a gradient instance.
module tb_lane_color_mapper_fx;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 Clk = ~Clk;

  lane_color_mapper_fx_if #(.N_LANES(8)) u_if ();
  lane_color_mapper_fx_if #(.N_LANES(8)) u_gif ();

  lane_color_mapper_fx #(
    .N_LANES(8), .FLASH_FRAMES(6), .GRADIENT(1'b0),
    .BG_R(8'h00), .BG_G(8'h00), .BG_B(8'h00)
  ) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(u_if.slave)
  );

  lane_color_mapper_fx #(
    .N_LANES(8), .FLASH_FRAMES(6), .GRADIENT(1'b1),
    .BG_R(8'h00), .BG_G(8'hF0), .BG_B(8'h00)
  ) u_gdut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(u_gif.slave)
  );

  wire [23:0] rgb  = {u_if.VGA_R, u_if.VGA_G, u_if.VGA_B};
  wire [23:0] grgb = {u_gif.VGA_R, u_gif.VGA_G, u_gif.VGA_B};

  task automatic check_rgb(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One frame_start pulse followed by an idle cycle so the new state reaches the output.
  task automatic frame();
    u_if.frame_start = 1'b1;
    tick();
    u_if.frame_start = 1'b0;
    tick();
  endtask

  initial begin
    u_if.frame_start = 0; u_if.DrawX = 0; u_if.DrawY = 0; u_if.is_num = 1;
    u_if.is_sr = 0; u_if.keyTrack = 0; u_if.hit = 0; u_if.miss = 0;
    u_gif.frame_start = 0; u_gif.DrawX = 0; u_gif.DrawY = 0; u_gif.is_num = 0;
    u_gif.is_sr = 0; u_gif.keyTrack = 0; u_gif.hit = 0; u_gif.miss = 0;

    // 1: reset, then digits
    tick(); tick();
    check_rgb("reset", rgb, 24'h000000);
    check_rgb("reset_g", grgb, 24'h000000);
    Reset_n = 1'b1;
    tick();
    check_rgb("num", rgb, 24'hFFFFFF);

    // 2: lane priority and key brightness
    u_if.is_num = 0; u_if.is_sr = 8'h11;
    tick();
    check_rgb("lane4_dim", rgb, 24'h00D600);
    u_if.keyTrack = 8'h10;
    tick();
    check_rgb("lane4_bright", rgb, 24'h00FD00);
    u_if.is_sr = 8'h08; u_if.keyTrack = 8'h00;
    tick();
    check_rgb("lane3_dim", rgb, 24'hAF0000);

    // 3: hit flash on lane 2 lasts 6 frames
    u_if.is_sr = 8'h04; u_if.hit = 8'h04;
    tick();
    check_rgb("hit2_edge1", rgb, 24'hF2F200);
    u_if.hit = 8'h00;
    tick();
    check_rgb("hit2_edge2", rgb, 24'hFFFF80);
    for (int f = 1; f <= 5; f++) begin
      frame();
      check_rgb($sformatf("hit2_f%0d", f), rgb, 24'hFFFF80);
    end
    frame();
    check_rgb("hit2_end", rgb, 24'hF2F200);

    // 4: hit beats miss; miss retrigger at the 3rd frame
    u_if.is_sr = 8'h02; u_if.hit = 8'h02; u_if.miss = 8'h02;
    tick();
    u_if.hit = 0; u_if.miss = 0;
    tick();
    check_rgb("hitmiss1", rgb, 24'h8080FF);
    frame(); frame();
    u_if.miss = 8'h02; u_if.frame_start = 1'b1;
    tick();
    u_if.miss = 0; u_if.frame_start = 1'b0;
    tick();
    check_rgb("miss1_load", rgb, 24'h600000);
    u_if.keyTrack = 8'h02;
    tick();
    check_rgb("miss1_key", rgb, 24'h600000);
    u_if.keyTrack = 8'h00;
    for (int f = 1; f <= 5; f++) begin
      frame();
      check_rgb($sformatf("miss1_f%0d", f), rgb, 24'h600000);
    end
    frame();
    check_rgb("miss1_end", rgb, 24'h0000C9);

    // 5: load with coincident frame_start, then reset mid-flash
    u_if.is_sr = 8'h01; u_if.hit = 8'h01; u_if.frame_start = 1'b1;
    tick();
    u_if.hit = 0; u_if.frame_start = 1'b0;
    tick();
    check_rgb("hit0_load", rgb, 24'h80FD80);
    for (int f = 1; f <= 5; f++) frame();
    check_rgb("hit0_f5", rgb, 24'h80FD80);
    Reset_n = 1'b0;
    tick();
    check_rgb("hit0_rst", rgb, 24'h000000);
    Reset_n = 1'b1;
    tick();
    check_rgb("hit0_idle", rgb, 24'h00D600);

    // 6: gradient saturation, offset, and DrawX independence
    u_if.is_sr = 8'h00;
    u_gif.DrawY = 10'd480;
    tick();
    check_rgb("grad_sat", grgb, 24'h00FF00);
    u_gif.DrawY = 10'd8;
    tick();
    check_rgb("grad_8", grgb, 24'h00F100);
    for (int x = 0; x < 640; x += 157) begin
      u_gif.DrawX = 10'(x); u_if.DrawX = 10'(x);
      tick();
      check_rgb($sformatf("drawx_g_%0d", x), grgb, 24'h00F100);
      check_rgb($sformatf("drawx_%0d", x), rgb, 24'h000000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
